// File: rtl/proc_pkg.sv
// Shared opcode, bus-width and timeout constants plus the data-memory sequencer state type.
package proc_pkg;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01100;
  localparam int         DM_AW      = 16;
  localparam int         DM_DW      = 16;
  localparam int         DM_CW      = 4;
  localparam logic [3:0] DM_TIMEOUT = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE,
    ST_ERR
  } dm_state_e;

  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == OPC_LOAD) || (op == OPC_STORE);
  endfunction

endpackage

// File: rtl/dm_timeout_ctr.sv
// Wait-cycle counter for an outstanding data-memory request; flags when the timeout count is reached.
module dm_timeout_ctr
  import proc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic at_limit
);

  logic [DM_CW-1:0] count_reg;

  // Saturates at the limit so a missed exit can never wrap back to a small count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !at_limit) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign at_limit = (count_reg == DM_TIMEOUT);

endmodule

// File: rtl/dm_access_sequencer.sv
// Sequences a single LOAD/STORE to data memory: request, wait for ack or timeout, then report.
module dm_access_sequencer
  import proc_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       opcode,
  input  logic             instr_valid,
  input  logic [DM_AW-1:0] alu_addr,
  input  logic [DM_DW-1:0] store_data,
  input  logic [DM_DW-1:0] dm_rdata,
  input  logic             dm_ack,
  output logic             dm_req,
  output logic             dm_we,
  output logic [DM_AW-1:0] dm_addr,
  output logic [DM_DW-1:0] dm_wdata,
  output logic             stall,
  output logic [DM_DW-1:0] load_data,
  output logic             load_valid,
  output logic             busy,
  output logic             timeout_err
);

  dm_state_e        state_reg;
  logic             dm_req_reg;
  logic             dm_we_reg;
  logic [DM_AW-1:0] dm_addr_reg;
  logic [DM_DW-1:0] dm_wdata_reg;
  logic [DM_DW-1:0] load_data_reg;
  logic             load_valid_reg;
  logic             timeout_err_reg;
  logic             accept;
  logic             at_limit;

  assign accept = (state_reg == ST_IDLE) && instr_valid && is_mem_op(opcode);

  dm_timeout_ctr u_timeout_ctr (
    .clk      (CLK),
    .rst      (RST),
    .clear    (accept),
    .enable   ((state_reg == ST_REQ) && !dm_ack),
    .at_limit (at_limit)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg       <= ST_IDLE;
      dm_req_reg      <= 1'b0;
      dm_we_reg       <= 1'b0;
      dm_addr_reg     <= '0;
      dm_wdata_reg    <= '0;
      load_data_reg   <= '0;
      load_valid_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      load_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            dm_addr_reg  <= alu_addr;
            dm_wdata_reg <= store_data;
            dm_we_reg    <= (opcode == OPC_STORE);
            dm_req_reg   <= 1'b1;
            state_reg    <= ST_REQ;
          end
        end
        ST_REQ: begin
          // An ack in the final wait cycle still completes the access.
          if (dm_ack) begin
            if (!dm_we_reg) begin
              load_data_reg <= dm_rdata;
            end
            load_valid_reg <= !dm_we_reg;
            dm_req_reg     <= 1'b0;
            state_reg      <= ST_DONE;
          end else if (at_limit) begin
            dm_req_reg      <= 1'b0;
            timeout_err_reg <= 1'b1;
            state_reg       <= ST_ERR;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        ST_ERR:  state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Stall must rise in the accept cycle itself, before any register can react.
  assign stall       = !RST && (accept || (state_reg == ST_REQ));
  assign busy        = (state_reg != ST_IDLE);
  assign dm_req      = dm_req_reg;
  assign dm_we       = dm_we_reg;
  assign dm_addr     = dm_addr_reg;
  assign dm_wdata    = dm_wdata_reg;
  assign load_data   = load_data_reg;
  assign load_valid  = load_valid_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: doc/dm_access_sequencer.md
DM_ACCESS_SEQUENCER -- requirements
Module: dm_access_sequencer

Interface
REQ-001 The block SHALL have port CLK, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have port opcode, input, 5 bits: decoded instruction opcode (LOAD=5'b00000, STORE=5'b01100).
REQ-004 The block SHALL have port instr_valid, input, 1 bit: opcode/addr/data valid this cycle.
REQ-005 The block SHALL have port alu_addr, input, 16 bits: effective address from the ALU.
REQ-006 The block SHALL have port store_data, input, 16 bits: register data for STORE.
REQ-007 The block SHALL have port dm_rdata, input, 16 bits: data memory read data, valid when dm_ack=1.
REQ-008 The block SHALL have port dm_ack, input, 1 bit: data memory completion strobe.
REQ-009 The block SHALL have port dm_req, output, 1 bit: memory request, registered.
REQ-010 The block SHALL have port dm_we, output, 1 bit: 1=write, 0=read, registered.
REQ-011 The block SHALL have ports dm_addr and dm_wdata, outputs, 16 bits each: latched address and write data.
REQ-012 The block SHALL have port stall, output, 1 bit: hold PC and pipeline.
REQ-013 The block SHALL have ports load_data (output, 16 bits) and load_valid (output, 1 bit): load result and one-cycle register-file write strobe.
REQ-014 The block SHALL have port busy, output, 1 bit: state != IDLE.
REQ-015 The block SHALL have port timeout_err, output, 1 bit: sticky timeout flag.

Function
REQ-016 The FSM SHALL have four states: IDLE, REQ, DONE, ERR.
REQ-017 In IDLE, when instr_valid=1 and opcode is LOAD or STORE, the block SHALL latch alu_addr, store_data, and dm_we (STORE=1) and move to REQ; other opcodes SHALL cause no action.
REQ-018 stall SHALL be 1 combinationally in the IDLE cycle a memory op is accepted and in every REQ cycle, and 0 in DONE, ERR, and idle-with-no-memory-op.
REQ-019 dm_req SHALL be 1 exactly while in REQ, and dm_addr, dm_wdata, and dm_we SHALL remain stable throughout REQ.
REQ-020 In REQ with dm_ack=1, the block SHALL capture dm_rdata into load_data (LOAD only) and move to DONE.
REQ-021 A 4-bit wait counter SHALL clear on entry to REQ and increment on each REQ cycle with dm_ack=0.
REQ-022 When the counter equals TIMEOUT (15) with dm_ack=0, the block SHALL move to ERR; if dm_ack=1 in that same cycle, the ack SHALL win and the block SHALL move to DONE.
REQ-023 DONE SHALL last one cycle, with load_valid=1 for LOAD and 0 for STORE, then return to IDLE.
REQ-024 ERR SHALL last one cycle, set timeout_err=1 (sticky until RST), with load_valid=0, then return to IDLE.
REQ-025 instr_valid in REQ, DONE, or ERR SHALL be ignored; a back-to-back op SHALL be accepted only in the following IDLE cycle.
REQ-026 dm_ack in IDLE, DONE, or ERR SHALL be ignored.
REQ-027 Minimum latency SHALL be: accept at cycle T, dm_req at T+1, ack at T+1, load_valid at T+2.

Reset
REQ-028 While RST=1, the block SHALL force state IDLE, counter 0, and dm_req, dm_we, stall, load_valid, busy, and timeout_err to 0, and dm_addr, dm_wdata, and load_data to 16'h0000.
REQ-029 RST asserted mid-REQ SHALL drop dm_req immediately (asynchronously), and the in-flight op SHALL be abandoned with no load_valid.

Structure
REQ-030 A shared package proc_pkg SHALL hold OPC_LOAD, OPC_STORE, DM_AW=16, DM_DW=16, DM_TIMEOUT=15, and the state enumeration.
REQ-031 The wait counter SHALL be one sub-module, dm_timeout_ctr (clear, enable, at_limit output).

Verification
REQ-032 The bench SHALL cover: LOAD addr 16'h0010, dm_ack at T+1 with rdata 16'hBEEF -> load_valid at T+2, load_data=16'hBEEF, stall high T..T+1.
REQ-033 The bench SHALL cover: STORE addr 16'h0020 data 16'h1234, ack after 3 wait cycles -> dm_we=1, dm_wdata=16'h1234 stable for 4 REQ cycles, load_valid never 1.
REQ-034 The bench SHALL cover: LOAD with no ack -> dm_req high 16 cycles, ERR, timeout_err=1 held through the next successful LOAD.
REQ-035 The bench SHALL cover: ack in the same cycle the counter hits 15 -> DONE, timeout_err stays 0.
REQ-036 The bench SHALL cover: RST pulse during REQ -> dm_req 0 before the next CLK edge, FSM in IDLE, all outputs zero.
REQ-037 The bench SHALL cover: opcode 5'b00010 with instr_valid=1 -> no dm_req, stall=0, busy=0.
